uart_tx_serializer: RTL



---
 rtl/uart_tx_serializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Frames a parallel word as start bit, data bits LSB first, an optional parity
// bit and a stop bit. It shifts the frame out at one bit per clock, because
// the clock is already the bit-rate clock.
//
// Ports
//   CLK         bit-rate clock, rising edge
//   RST         synchronous active-high reset; aborts any frame in flight
//   P_DATA      parallel word, sampled on accept
//   DATA_VALID  request strobe, only looked at while Busy is low
//   PAR_EN      1 = append a parity bit (sampled on accept)
//   PAR_TYP     0 = even parity, 1 = odd parity (sampled on accept)
//   TX_OUT      serial line, idles high (registered)
//   Busy        high from the start bit through the stop bit (registered)
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int data_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [data_Width-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    // Keep the counter at least one bit wide so a 1-bit data width still elaborates.
    localparam int CW = (data_Width > 1) ? $clog2(data_Width) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(data_Width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [data_Width-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic                  tx_reg;
    logic                  busy_reg;

    logic [CW-1:0]         cnt_next;
    logic                  par_bit;

    assign cnt_next = cnt_reg + CW'(1);
    // Even parity makes the total count of ones even, so the bit is the XOR of the data.
    assign par_bit  = par_typ_reg ? ~^data_reg : ^data_reg;

    // The outputs are registered. Each transition loads tx_reg/busy_reg with the
    // values for the state being entered, so the line value always matches
    // state_reg in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    if (DATA_VALID) begin
                        data_reg    <= P_DATA;
                        par_en_reg  <= PAR_EN;
                        par_typ_reg <= PAR_TYP;
                        state_reg   <= START;
                        tx_reg      <= 1'b0;
                        busy_reg    <= 1'b1;
                    end
                end
                START: begin
                    state_reg <= DATA;
                    cnt_reg   <= '0;
                    tx_reg    <= data_reg[0];
                end
                DATA: begin
                    if (cnt_reg == LAST_BIT) begin
                        cnt_reg <= '0;
                        if (par_en_reg) begin
                            state_reg <= PARITY;
                            tx_reg    <= par_bit;
                        end else begin
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_next;
                        tx_reg  <= data_reg[cnt_next];
                    end
                end
                PARITY: begin
                    state_reg <= STOP;
                    tx_reg    <= 1'b1;
                end
                STOP: begin
                    // DATA_VALID is deliberately not examined here. The earliest
                    // accept is the following IDLE cycle, which gives one idle-high
                    // bit between back-to-back frames.
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_reg;
    assign Busy   = busy_reg;

endmodule
